// File: rtl/stream_mux_if.sv
// Valid/ready bundle for stream_mux: N input channels packed side by side,
// one registered output stream, and the arbitration mode select.
interface stream_mux_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  localparam int SEL_W = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_last;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [WIDTH-1:0]   out_data;
  logic               out_last;
  logic [SEL_W-1:0]   out_chan;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_data, in_valid, in_last, mode, out_ready,
    input  in_ready, out_data, out_last, out_chan, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, mode, out_ready,
    output in_ready, out_data, out_last, out_chan, out_valid
  );
endinterface

// File: rtl/stream_mux.sv
// N-channel stream multiplexer: packet-locked round-robin / fixed-priority
// arbitration feeding a single registered output beat (one cycle latency).
module stream_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input logic         clk,
  input logic         reset_n,
  stream_mux_if.slave bus
);
  localparam int SEL_W = $clog2(N);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] lock_chan_q, lock_chan_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic             rel_q, rel_d;

  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] cand;
  logic             have_grant;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;
  logic             sel_valid;
  logic             can_load;
  logic             in_xfer;
  logic [N-1:0]     in_ready;

  // Both searches walk backwards so the last hit is the highest-priority one.
  always_comb begin
    grant      = lock_chan_q;
    have_grant = 1'b0;
    cand       = '0;
    if (state_q == LOCKED) begin
      have_grant = 1'b1;
    end else if (bus.mode) begin
      for (int unsigned i = N; i > 0; i--) begin
        cand = SEL_W'(i - 1);
        if (bus.in_valid[cand]) begin
          grant      = cand;
          have_grant = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = N; k > 0; k--) begin
        cand = SEL_W'((32'(rr_ptr_q) + k) % N);
        if (bus.in_valid[cand]) begin
          grant      = cand;
          have_grant = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant == SEL_W'(i)) begin
        sel_data  = bus.in_data[i*WIDTH +: WIDTH];
        sel_last  = bus.in_last[SEL_W'(i)];
        sel_valid = bus.in_valid[SEL_W'(i)];
      end
    end
  end

  // rel_q keeps every in_ready low until the first clock after reset release.
  always_comb begin
    can_load = !out_valid_q || bus.out_ready;
    in_ready = '0;
    if (rel_q && can_load && have_grant) begin
      in_ready[grant] = 1'b1;
    end
    in_xfer = rel_q && can_load && have_grant && sel_valid;
  end

  always_comb begin
    state_d     = state_q;
    lock_chan_d = lock_chan_q;
    rr_ptr_d    = rr_ptr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    rel_d       = 1'b1;
    if (in_xfer) begin
      out_data_d  = sel_data;
      out_last_d  = sel_last;
      out_chan_d  = grant;
      out_valid_d = 1'b1;
      if (sel_last) begin
        state_d  = IDLE;
        rr_ptr_d = grant;
      end else begin
        state_d     = LOCKED;
        lock_chan_d = grant;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      lock_chan_q <= '0;
      rr_ptr_q    <= SEL_W'(N - 1);
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      rel_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_chan_q <= lock_chan_d;
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      rel_q       <= rel_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: doc/stream_mux.md
# stream_mux

Parametrised N-channel valid/ready stream multiplexer with packet-level arbitration and a registered output stage. It is the sequential successor to the plain select-driven muxes in the datapath. Several producers share one consumer, for example instruction-fetch and load/store requesters sharing a memory port. The block arbitrates between channels in round-robin or fixed-priority mode and holds the grant for a whole packet, delimited by `last`. It delivers one beat per cycle with one cycle of latency.

## Interface
- `WIDTH`, 32, data width per channel.
- `N`, 4, number of input channels; N ≥ 2.
- `SEL_W`, `$clog2(N)`, width of channel index (derived, not overridden).

- `clk`  in  1  clock; all state on rising edge.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `in_data`  in  N*WIDTH  channel i at bits `[i*WIDTH +: WIDTH]`.
- `in_valid`  in  N  per-channel beat valid.
- `in_last`  in  N  per-channel last beat of packet.
- `in_ready`  out  N  per-channel accept; at most one bit high.
- `mode`  in  1  0 = round-robin, 1 = fixed priority (channel 0 highest).
- `out_data`  out  WIDTH  registered beat.
- `out_last`  out  1  registered last flag.
- `out_chan`  out  SEL_W  source channel of the current output beat.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  consumer accept.

## Operation
- **Transfers.** An input transfer on channel i occurs when `in_valid[i] & in_ready[i]`. An output transfer occurs when `out_valid & out_ready`.
- **Output register.** It accepts a beat when `can_load = !out_valid | out_ready`. With `in_ready[g] = can_load & (grant == g)`, all other `in_ready` bits are 0.
- **FSM state IDLE.**
  - `grant` is combinational from `in_valid`, `mode` and `rr_ptr`.
  - Round-robin mode: grant goes to the first valid channel searching `rr_ptr+1, rr_ptr+2, …` modulo N.
  - Fixed mode: grant goes to the lowest-index valid channel.
  - If no channel is valid, no `in_ready` is asserted.
- **FSM state LOCKED.**
  - `grant = lock_chan` regardless of other `in_valid` bits and regardless of `mode`.
  - Other channels are never readied.
- **IDLE transitions.**
  - Transfer with `in_last=0`: go to LOCKED, `lock_chan <= grant`.
  - Transfer with `in_last=1`, a single-beat packet: stay IDLE.
- **LOCKED transitions.**
  - Transfer with `in_last=1`: go to IDLE.
  - Otherwise stay LOCKED.
- **Pointer update.** On every transfer with `in_last=1`, `rr_ptr <= source channel`. This update happens in both modes.
- **Output register load.** On input transfer: `out_data <= in_data[grant]`, `out_last <= in_last[grant]`, `out_chan <= grant`, `out_valid <= 1`.
- **Output register clear.** On output transfer with no input transfer: `out_valid <= 0`. Data fields hold their last value.
- **Mode changes.** `mode` is only sampled in IDLE. Changing it mid-packet has no effect until the packet ends.
- **Input rule.** Sources keep `in_valid`, `in_data` and `in_last` stable until accepted. The block does not check this. A channel dropping `in_valid` in LOCKED stalls the packet; the block stays LOCKED.

## Timing
- **Reset values** (asynchronous on `reset_n` low): `out_valid=0`, `out_last=0`, `out_data=0`, `out_chan=0`, FSM=IDLE, `lock_chan=0`, `rr_ptr=N-1` (so channel 0 wins first in round-robin).
- **`in_ready`.** While `reset_n` is low, all `in_ready` are 0 because `can_load` depends on `out_valid=0` but the FSM is forced; `in_ready` is gated with an internal reset-released flag that sets on the first clock after deassertion.
- **Latency.** A beat accepted in cycle t appears on the output with `out_valid=1` in cycle t+1.
- **Throughput.** 1 beat/cycle sustained while `out_ready=1`. Simultaneous load and unload in one cycle is legal: the register is replaced and `out_valid` stays 1.
- **Backpressure.** `out_ready=0` with `out_valid=1` makes all `in_ready` 0 in the same cycle (combinational path `out_ready → in_ready`). The output fields are held stable.
- **Grant timing.** Grant switch between packets takes zero bubbles. The beat after a `last` transfer may come from another channel in the next cycle.
- **Reset mid-packet.** The packet is discarded, the FSM returns to IDLE, and the partial packet is not completed downstream.

## Test plan
- **Reset and single beat.** After reset, channel 2 sends one beat `0xA5A5_0002` with last, `out_ready=1`. Required: `in_ready=4'b0100` that cycle; next cycle `out_valid=1`, `out_data=0xA5A5_0002`, `out_chan=2`, `out_last=1`.
- **Round-robin fairness.** `mode=0`, all 4 channels continuously offering single-beat packets, `out_ready=1`. Required: `out_chan` sequence 0,1,2,3,0,1,… with no idle cycles.
- **Packet lock.** Channel 1 sends a 3-beat packet while channel 0 is valid throughout. Required: three consecutive beats with `out_chan=1`, `out_last` only on the 3rd, then channel 0 granted.
- **Fixed priority and mode change.** `mode=1` with channels 0 and 3 valid: channel 0 always wins. Then toggle `mode` mid-packet on channel 3: the lock still completes the packet.
- **Backpressure.** Hold `out_ready=0` for 5 cycles with `out_valid=1`. Required: `in_ready=0`, `out_data` stable. Release: the next beat follows in the next cycle, with no loss or duplication (scoreboard check).
- **Async reset mid-packet.** Assert `reset_n=0` between clock edges during a 4-beat packet. Required: `out_valid` drops immediately, the FSM is IDLE after release, and channel 0 has first priority.
